// File: rtl/morse_rx_decoder_if.sv
// Keyed-line input and decoded-character output bundle for morse_rx_decoder.
// master: pin/enable source and character sink; slave: the decoder.
interface morse_rx_decoder_if;
  logic       Pin_In;
  logic       Enable;
  logic [4:0] Sym_Code;
  logic [2:0] Sym_Len;
  logic       Char_Valid;
  logic       SOS_Det;
  logic       Err_Sig;

  modport master (
    output Pin_In, Enable,
    input  Sym_Code, Sym_Len, Char_Valid, SOS_Det, Err_Sig
  );

  modport slave (
    input  Pin_In, Enable,
    output Sym_Code, Sym_Len, Char_Valid, SOS_Det, Err_Sig
  );
endinterface

// File: rtl/morse_rx_decoder.sv
// Morse receiver: times active-low marks/spaces in ms ticks, emits characters.
// Optional level debounce after the synchronizer: MORSE_RX_DEBOUNCE_EN.
module morse_rx_decoder #(
`ifdef MORSE_RX_DEBOUNCE_EN
  parameter logic [15:0] DEB_CYCLES  = 16'd250,
`endif
  parameter logic [15:0] T1MS        = 16'd49_999,
  parameter logic [9:0]  MARK_MIN_MS = 10'd20,
  parameter logic [9:0]  DASH_MIN_MS = 10'd200,
  parameter logic [9:0]  GAP_CHAR_MS = 10'd300
) (
  input  logic              CLK,
  input  logic              RSTn,
  morse_rx_decoder_if.slave rx
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, STUCK} state_t;

  localparam logic [9:0]  MS_MAX  = 10'h3FF;
  localparam logic [23:0] SOS_SEQ = {8'h60, 8'h67, 8'h60};

  state_t          state_q, state_d;
  logic            sync1, sync2, lvl, lvl_q;
  logic            rise, fall, tick, restart;
  logic [15:0]     cnt_q;
  logic [9:0]      ms_q;
  logic [4:0]      code_q, code_d;
  logic [2:0]      len_q, len_d;
  logic            emit, err, hist_clr, sos_hit;
  logic [2:0][7:0] hist_q;
  logic [4:0]      sym_code_q;
  logic [2:0]      sym_len_q;
  logic            cv_q, sos_q, err_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      lvl_q <= 1'b1;
    end else begin
      sync1 <= rx.Pin_In;
      sync2 <= sync1;
      lvl_q <= lvl;
    end
  end

`ifdef MORSE_RX_DEBOUNCE_EN
  logic [15:0] deb_cnt;
  logic        deb_lvl;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      deb_cnt <= '0;
      deb_lvl <= 1'b1;
    end else if (sync2 == deb_lvl) begin
      deb_cnt <= '0;
    end else if (deb_cnt == DEB_CYCLES - 16'd1) begin
      deb_cnt <= '0;
      deb_lvl <= sync2;
    end else begin
      deb_cnt <= deb_cnt + 16'd1;
    end
  end

  assign lvl = deb_lvl;
`else
  assign lvl = sync2;
`endif

  assign rise    = lvl & ~lvl_q;
  assign fall    = ~lvl & lvl_q;
  assign tick    = (cnt_q == T1MS);
  assign restart = (state_d != state_q);
  assign sos_hit = rx.Enable && cv_q && (hist_q == SOS_SEQ);

  // Both counters restart on every state change so each mark/space is timed alone.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt_q <= '0;
      ms_q  <= '0;
    end else if (state_q == IDLE || restart) begin
      cnt_q <= '0;
      ms_q  <= '0;
    end else if (tick) begin
      cnt_q <= '0;
      if (ms_q != MS_MAX) ms_q <= ms_q + 10'd1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    len_d    = len_q;
    emit     = 1'b0;
    err      = 1'b0;
    hist_clr = 1'b0;
    if (!rx.Enable) begin
      state_d  = IDLE;
      code_d   = '0;
      len_d    = '0;
      hist_clr = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          code_d = '0;
          len_d  = '0;
          if (!lvl) state_d = MARK;
        end
        MARK: begin
          if (rise) begin
            if (ms_q < MARK_MIN_MS) begin
              state_d = (len_q != 3'd0) ? SPACE : IDLE;
            end else if (len_q == 3'd5) begin
              err      = 1'b1;
              code_d   = '0;
              len_d    = '0;
              hist_clr = 1'b1;
              state_d  = IDLE;
            end else begin
              code_d  = {code_q[3:0], (ms_q >= DASH_MIN_MS)};
              len_d   = len_q + 3'd1;
              state_d = SPACE;
            end
          end else if (ms_q == MS_MAX) begin
            err      = 1'b1;
            code_d   = '0;
            len_d    = '0;
            hist_clr = 1'b1;
            state_d  = STUCK;
          end
        end
        SPACE: begin
          if (ms_q == GAP_CHAR_MS) begin
            emit    = 1'b1;
            code_d  = '0;
            len_d   = '0;
            state_d = fall ? MARK : IDLE;
          end else if (fall) begin
            state_d = MARK;
          end
        end
        STUCK: begin
          if (lvl) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      code_q     <= '0;
      len_q      <= '0;
      hist_q     <= '0;
      sym_code_q <= '0;
      sym_len_q  <= '0;
      cv_q       <= 1'b0;
      sos_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      len_q   <= len_d;
      cv_q    <= emit;
      err_q   <= err;
      sos_q   <= sos_hit;
      if (emit) begin
        sym_code_q <= code_q;
        sym_len_q  <= len_q;
      end
      // A detected S-O-S consumes the history so sequences never overlap.
      if (hist_clr || sos_hit) hist_q <= '0;
      else if (emit) hist_q <= {hist_q[1:0], {len_q, code_q}};
    end
  end

  assign rx.Sym_Code   = sym_code_q;
  assign rx.Sym_Len    = sym_len_q;
  assign rx.Char_Valid = cv_q;
  assign rx.SOS_Det    = sos_q;
  assign rx.Err_Sig    = err_q;

endmodule
